psresp_seq: RTL and testbench
=============================

# psresp_seq

Slave page-response sequencer for the baseband link controller. It walks page scan through the response substates (ID response, FHS receive, FHS ack, new-connection wait) and drives the substate flags consumed by the frequency-hop kernel control. It also generates the `fkset_p` PLL-setup strobe ahead of each half-slot boundary and enforces the pagerespTO and newconnectionTO timeouts. It sits between the baseband slot timing and the hop-kernel/correlator datapath.

## Interface
- `HALF_SLOT_CYC`, 1875: clk_6M cycles per 312.5 us half slot.
- `FKSET_LEAD`, 900: cycles `fkset_p` precedes the half-slot boundary (150 us).
- `PAGERESP_TO`, 8: slots allowed in PSRXFHS.
- `NEWCONN_TO`, 32: slots allowed in CONNSNEWSLAVE.
- `clk_6M` in 1: 6 MHz clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `ps_en` in 1: page scan enabled.
- `corre_threshold` in 1: access-code correlation hit.
- `tx_done_p` in 1: ID packet transmission complete.
- `rx_fhs_ok_p` in 1: FHS received, CRC good.
- `rx_poll_ok_p` in 1: first master packet received in new connection.
- `detach_p` in 1: leave CONN.
- `tslot_p` in 1: slot-boundary tick.
- `half_tslot_p` in 1: half-slot-boundary tick.
- `fkset_ext_p` in 1: external PLL-setup strobe, used when the generator is compiled out.
- `ps`, `pstxid`, `psrxfhs`, `psackfhs`, `connsnewslave`, `conn` out 1 each: one-hot substate flags, all 0 in IDLE.
- `fkset_p` out 1: PLL setup strobe.
- `pageresp_to_p`, `newconn_to_p`, `conn_up_p` out 1 each: one-cycle event pulses.

## Operation
- States: IDLE, PS, PSTXID, PSRXFHS, PSACKFHS, CONNSNEWSLAVE, CONN. Each state flag is a registered decode of the state register.
- Transitions:
  - IDLE→PS when `ps_en`.
  - PS→PSTXID on `corre_threshold`.
  - PSTXID→PSRXFHS on `tx_done_p`.
  - PSRXFHS→PSACKFHS on `rx_fhs_ok_p`.
  - PSACKFHS→CONNSNEWSLAVE on `tx_done_p`.
  - CONNSNEWSLAVE→CONN on `rx_poll_ok_p`, with `conn_up_p`.
  - CONN→IDLE on `detach_p`.
- Slot timer: 6-bit. Cleared on entry to PSRXFHS and on entry to CONNSNEWSLAVE. Increments on `tslot_p` in those two states and is frozen elsewhere.
- pagerespTO: in PSRXFHS, a `tslot_p` that brings the timer to `PAGERESP_TO` → PS and `pageresp_to_p`.
- newconnectionTO: in CONNSNEWSLAVE, a `tslot_p` that brings the timer to `NEWCONN_TO` → PS and `newconn_to_p`.
- Priority:
  - `rst` overrides everything.
  - `ps_en`=0 in any state except IDLE and CONN → IDLE, no pulse.
  - A success event beats a timeout in the same cycle; the timeout pulse is suppressed.
  - In PS, `corre_threshold` takes effect regardless of timer ticks.
- Inputs irrelevant to the current state are ignored.
- `ps_en` is not examined in CONN.

## Timing
- Reset values: state IDLE, all flags 0, all pulses 0, `fkset_p` 0, slot timer 0, half-slot counter 0.
- Latency: an input event in cycle n changes the state flags in cycle n+1. Event pulses are registered and asserted in cycle n+1 for exactly one cycle.
- Half-slot counter: 11 bits.
  - Loads 0 in the cycle `half_tslot_p` is high.
  - Otherwise increments, saturating at `HALF_SLOT_CYC-1`.
- `fkset_p` = (counter == `HALF_SLOT_CYC-1-FKSET_LEAD`), i.e. 974 with defaults. It is a one-cycle strobe, 975 cycles after `half_tslot_p`.
- Arithmetic: slot-timer compare uses the incremented value. No wrap is possible because the timeout fires first.

## Configuration
- `PSRESP_FKSET_GEN_EN` defined: internal half-slot counter drives `fkset_p`; `fkset_ext_p` is ignored.
- `PSRESP_FKSET_GEN_EN` undefined: counter is removed and `fkset_p` = `fkset_ext_p` (combinational pass-through). All other behaviour is identical.

## Structure
- `psresp_pkg` holds:
  - the state enum;
  - default constants for `HALF_SLOT_CYC`, `FKSET_LEAD`, `PAGERESP_TO`, `NEWCONN_TO`;
  - slot-timer and half-slot-counter widths.
- Sub-module `fkset_gen`: half-slot counter plus strobe decode. It is instantiated only under `PSRESP_FKSET_GEN_EN`.

## Test plan
- Reset: hold `rst` 3 cycles mid-PSRXFHS → next cycle all flags/pulses 0, state IDLE, `fkset_p` 0.
- Happy path: `ps_en`=1, `corre_threshold`, `tx_done_p`, `rx_fhs_ok_p`, `tx_done_p`, `rx_poll_ok_p` → flags step ps→pstxid→psrxfhs→psackfhs→connsnewslave→conn, each one cycle after its event; `conn_up_p` 1 cycle.
- pagerespTO: enter PSRXFHS, 8 `tslot_p`, no FHS → the cycle after the 8th tick `ps`=1 and `pageresp_to_p`=1 for one cycle.
- Collision: `rx_fhs_ok_p` in the same cycle as the 8th `tslot_p` → PSACKFHS, `pageresp_to_p` stays 0.
- Abort: `ps_en`→0 in CONNSNEWSLAVE after 10 slots → IDLE next cycle; re-enter the state later and confirm the timeout needs a full 32 slots.
- fkset: `half_tslot_p` every 1875 cycles → `fkset_p` high exactly at offset 975 from each tick. With the macro undefined, `fkset_p` mirrors `fkset_ext_p` in the same cycle.

Source files
------------

// File: rtl/psresp_pkg.sv
// Shared types and default constants for the slave page-response sequencer.
// Defines the substate enum, timing defaults and the substate flag decode.
package psresp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PS,
        ST_PSTXID,
        ST_PSRXFHS,
        ST_PSACKFHS,
        ST_CONNSNEWSLAVE,
        ST_CONN
    } psresp_state_e;

    localparam int HALF_SLOT_CYC_DEF = 1875;
    localparam int FKSET_LEAD_DEF    = 900;
    localparam int PAGERESP_TO_DEF   = 8;
    localparam int NEWCONN_TO_DEF    = 32;

    localparam int SLOT_TMR_W = 6;
    localparam int HALF_CNT_W = 11;

    typedef struct packed {
        logic ps;
        logic pstxid;
        logic psrxfhs;
        logic psackfhs;
        logic connsnewslave;
        logic conn;
    } psresp_flags_t;

    // One-hot substate flags; IDLE (and any illegal encoding) decodes to all zero.
    function automatic psresp_flags_t decode_flags(input psresp_state_e s);
        psresp_flags_t f;
        f = '0;
        case (s)
            ST_PS:            f.ps            = 1'b1;
            ST_PSTXID:        f.pstxid        = 1'b1;
            ST_PSRXFHS:       f.psrxfhs       = 1'b1;
            ST_PSACKFHS:      f.psackfhs      = 1'b1;
            ST_CONNSNEWSLAVE: f.connsnewslave = 1'b1;
            ST_CONN:          f.conn          = 1'b1;
            default:          f               = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/psresp_seq_fkset_gen.sv
// Half-slot counter that produces the fkset_p PLL-setup strobe FKSET_LEAD
// cycles before each half-slot boundary. Only used with PSRESP_FKSET_GEN_EN.
module fkset_gen
    import psresp_pkg::*;
#(
    parameter int HALF_SLOT_CYC = HALF_SLOT_CYC_DEF,
    parameter int FKSET_LEAD    = FKSET_LEAD_DEF
) (
    input  logic clk_6M,
    input  logic rst,
    input  logic half_tslot_p,
    output logic fkset_p
);

    localparam logic [HALF_CNT_W-1:0] CNT_MAX   = HALF_CNT_W'(HALF_SLOT_CYC - 1);
    localparam logic [HALF_CNT_W-1:0] STROBE_AT = HALF_CNT_W'(HALF_SLOT_CYC - 1 - FKSET_LEAD);

    logic [HALF_CNT_W-1:0] cnt;

    // Saturates so a missing boundary tick never produces a second strobe.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            cnt <= '0;
        end else if (half_tslot_p) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fkset_p = (cnt == STROBE_AT);

endmodule

// File: rtl/psresp_seq.sv
// Slave page-response sequencer: substate FSM, slot timeouts and fkset_p.
// Define PSRESP_FKSET_GEN_EN to generate fkset_p internally instead of passing fkset_ext_p.
module psresp_seq
    import psresp_pkg::*;
#(
    parameter int HALF_SLOT_CYC = HALF_SLOT_CYC_DEF,
    parameter int FKSET_LEAD    = FKSET_LEAD_DEF,
    parameter int PAGERESP_TO   = PAGERESP_TO_DEF,
    parameter int NEWCONN_TO    = NEWCONN_TO_DEF
) (
    input  logic clk_6M,
    input  logic rst,
    input  logic ps_en,
    input  logic corre_threshold,
    input  logic tx_done_p,
    input  logic rx_fhs_ok_p,
    input  logic rx_poll_ok_p,
    input  logic detach_p,
    input  logic tslot_p,
    input  logic half_tslot_p,
    input  logic fkset_ext_p,
    output logic ps,
    output logic pstxid,
    output logic psrxfhs,
    output logic psackfhs,
    output logic connsnewslave,
    output logic conn,
    output logic fkset_p,
    output logic pageresp_to_p,
    output logic newconn_to_p,
    output logic conn_up_p
);

    localparam logic [SLOT_TMR_W-1:0] PRESP_LIM = SLOT_TMR_W'(PAGERESP_TO);
    localparam logic [SLOT_TMR_W-1:0] NCONN_LIM = SLOT_TMR_W'(NEWCONN_TO);

    psresp_state_e         state;
    psresp_state_e         state_next;
    psresp_flags_t         flags;
    logic [SLOT_TMR_W-1:0] slot_tmr;
    logic [SLOT_TMR_W-1:0] slot_inc;
    logic                  slot_clear;
    logic                  slot_run;
    logic                  pto_next;
    logic                  nto_next;
    logic                  up_next;

    assign slot_inc   = slot_tmr + 1'b1;
    assign slot_run   = (state == ST_PSRXFHS) || (state == ST_CONNSNEWSLAVE);
    assign slot_clear = ((state_next == ST_PSRXFHS)       && (state != ST_PSRXFHS)) ||
                        ((state_next == ST_CONNSNEWSLAVE) && (state != ST_CONNSNEWSLAVE));

    // Dropping ps_en wins over everything in the page-response substates;
    // a success event always wins over a coincident timeout.
    always_comb begin
        state_next = state;
        pto_next   = 1'b0;
        nto_next   = 1'b0;
        up_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ps_en) state_next = ST_PS;
            end
            ST_CONN: begin
                if (detach_p) state_next = ST_IDLE;
            end
            default: begin
                if (!ps_en) begin
                    state_next = ST_IDLE;
                end else begin
                    case (state)
                        ST_PS: begin
                            if (corre_threshold) state_next = ST_PSTXID;
                        end
                        ST_PSTXID: begin
                            if (tx_done_p) state_next = ST_PSRXFHS;
                        end
                        ST_PSRXFHS: begin
                            if (rx_fhs_ok_p) begin
                                state_next = ST_PSACKFHS;
                            end else if (tslot_p && (slot_inc == PRESP_LIM)) begin
                                state_next = ST_PS;
                                pto_next   = 1'b1;
                            end
                        end
                        ST_PSACKFHS: begin
                            if (tx_done_p) state_next = ST_CONNSNEWSLAVE;
                        end
                        ST_CONNSNEWSLAVE: begin
                            if (rx_poll_ok_p) begin
                                state_next = ST_CONN;
                                up_next    = 1'b1;
                            end else if (tslot_p && (slot_inc == NCONN_LIM)) begin
                                state_next = ST_PS;
                                nto_next   = 1'b1;
                            end
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Flags decode the next state so they change together with the state register.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state         <= ST_IDLE;
            flags         <= '0;
            pageresp_to_p <= 1'b0;
            newconn_to_p  <= 1'b0;
            conn_up_p     <= 1'b0;
        end else begin
            state         <= state_next;
            flags         <= decode_flags(state_next);
            pageresp_to_p <= pto_next;
            newconn_to_p  <= nto_next;
            conn_up_p     <= up_next;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            slot_tmr <= '0;
        end else if (slot_clear) begin
            slot_tmr <= '0;
        end else if (slot_run && tslot_p) begin
            slot_tmr <= slot_inc;
        end
    end

    assign ps            = flags.ps;
    assign pstxid        = flags.pstxid;
    assign psrxfhs       = flags.psrxfhs;
    assign psackfhs      = flags.psackfhs;
    assign connsnewslave = flags.connsnewslave;
    assign conn          = flags.conn;

`ifdef PSRESP_FKSET_GEN_EN
    logic unused_fkset_ext;
    assign unused_fkset_ext = fkset_ext_p;

    fkset_gen #(
        .HALF_SLOT_CYC (HALF_SLOT_CYC),
        .FKSET_LEAD    (FKSET_LEAD)
    ) u_fkset_gen (
        .clk_6M       (clk_6M),
        .rst          (rst),
        .half_tslot_p (half_tslot_p),
        .fkset_p      (fkset_p)
    );
`else
    // Without the generator the strobe comes straight from outside.
    logic                  unused_half_tslot;
    logic [HALF_CNT_W-1:0] unused_fkset_cfg;
    assign unused_half_tslot = half_tslot_p;
    assign unused_fkset_cfg  = HALF_CNT_W'(HALF_SLOT_CYC - 1 - FKSET_LEAD);
    assign fkset_p           = fkset_ext_p;
`endif

endmodule

// File: tb/tb_psresp_seq.sv
// Self-checking bench for psresp_seq: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the page-response procedure.
module tb_psresp_seq;

    localparam int PAGERESP_TO = 8;
    localparam int NEWCONN_TO  = 32;
    localparam int HALF_SLOT   = 1875;
    localparam int FKSET_OFS   = 975;

    localparam int M_IDLE = 0, M_PS = 1, M_TXID = 2, M_RXFHS = 3, M_ACK = 4, M_NEW = 5, M_CONN = 6;

    localparam int E_CORRE = 1, E_TXD = 2, E_FHS = 4, E_POLL = 8;
    localparam int E_DET = 16, E_TS = 32, E_HTS = 64, E_EXT = 128;

    logic clk_6M = 1'b0;
    logic rst = 1'b1, ps_en = 1'b0, corre_threshold = 1'b0, tx_done_p = 1'b0;
    logic rx_fhs_ok_p = 1'b0, rx_poll_ok_p = 1'b0, detach_p = 1'b0, tslot_p = 1'b0;
    logic half_tslot_p = 1'b0, fkset_ext_p = 1'b0;
    logic ps, pstxid, psrxfhs, psackfhs, connsnewslave, conn;
    logic fkset_p, pageresp_to_p, newconn_to_p, conn_up_p;

    int errors = 0;
    int checks = 0;

    int m_st = M_IDLE;
    int m_slots = 0;
    int m_age = 1;
    bit m_pto = 0, m_nto = 0, m_up = 0, m_ext = 0;

    always #5 clk_6M = ~clk_6M;

    psresp_seq dut (
        .clk_6M          (clk_6M),
        .rst             (rst),
        .ps_en           (ps_en),
        .corre_threshold (corre_threshold),
        .tx_done_p       (tx_done_p),
        .rx_fhs_ok_p     (rx_fhs_ok_p),
        .rx_poll_ok_p    (rx_poll_ok_p),
        .detach_p        (detach_p),
        .tslot_p         (tslot_p),
        .half_tslot_p    (half_tslot_p),
        .fkset_ext_p     (fkset_ext_p),
        .ps              (ps),
        .pstxid          (pstxid),
        .psrxfhs         (psrxfhs),
        .psackfhs        (psackfhs),
        .connsnewslave   (connsnewslave),
        .conn            (conn),
        .fkset_p         (fkset_p),
        .pageresp_to_p   (pageresp_to_p),
        .newconn_to_p    (newconn_to_p),
        .conn_up_p       (conn_up_p)
    );

    function automatic logic [5:0] obs_flags();
        return {ps, pstxid, psrxfhs, psackfhs, connsnewslave, conn};
    endfunction

    function automatic logic [2:0] obs_pulses();
        return {pageresp_to_p, newconn_to_p, conn_up_p};
    endfunction

    function automatic logic [5:0] exp_flags(input int st);
        logic [5:0] f;
        f = '0;
        if (st != M_IDLE) f[6 - st] = 1'b1;
        return f;
    endfunction

    function automatic bit exp_fkset();
`ifdef PSRESP_FKSET_GEN_EN
        return (m_age == FKSET_OFS);
`else
        return m_ext;
`endif
    endfunction

    // Procedure-level model: what the link controller should do with this cycle's inputs.
    task automatic model(input bit r, input bit en, input int ev);
        bit ts;
        ts = (ev & E_TS) != 0;
        m_pto = 0; m_nto = 0; m_up = 0;
        m_ext = (ev & E_EXT) != 0;
        if (r) begin
            m_st  = M_IDLE;
            m_age = 1;
            return;
        end
        if ((ev & E_HTS) != 0) m_age = 1;
        else if (m_age < 100000) m_age++;
        if (m_st == M_IDLE) begin
            if (en) m_st = M_PS;
        end else if (m_st == M_CONN) begin
            if ((ev & E_DET) != 0) m_st = M_IDLE;
        end else if (!en) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_PS:   if ((ev & E_CORRE) != 0) m_st = M_TXID;
                M_TXID: if ((ev & E_TXD) != 0) begin m_st = M_RXFHS; m_slots = 0; end
                M_RXFHS: begin
                    if (ts) m_slots++;
                    if ((ev & E_FHS) != 0) m_st = M_ACK;
                    else if (ts && m_slots >= PAGERESP_TO) begin m_st = M_PS; m_pto = 1; end
                end
                M_ACK:  if ((ev & E_TXD) != 0) begin m_st = M_NEW; m_slots = 0; end
                M_NEW: begin
                    if (ts) m_slots++;
                    if ((ev & E_POLL) != 0) begin m_st = M_CONN; m_up = 1; end
                    else if (ts && m_slots >= NEWCONN_TO) begin m_st = M_PS; m_nto = 1; end
                end
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit en, input int ev);
        rst             = r;
        ps_en           = en;
        corre_threshold = (ev & E_CORRE) != 0;
        tx_done_p       = (ev & E_TXD) != 0;
        rx_fhs_ok_p     = (ev & E_FHS) != 0;
        rx_poll_ok_p    = (ev & E_POLL) != 0;
        detach_p        = (ev & E_DET) != 0;
        tslot_p         = (ev & E_TS) != 0;
        half_tslot_p    = (ev & E_HTS) != 0;
        fkset_ext_p     = (ev & E_EXT) != 0;
        model(r, en, ev);
        @(posedge clk_6M);
        #1;
    endtask

    task automatic reach_rxfhs();
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, E_CORRE);
        step(0, 1, E_TXD);
    endtask

    task automatic reach_newconn();
        reach_rxfhs();
        step(0, 1, E_FHS);
        step(0, 1, E_TXD);
    endtask

    task automatic test_reset();
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        checks++;
        if (obs_flags() !== 6'b000000) begin errors++; $display("[TB] FAIL reset_flags: got %b want %b", obs_flags(), 6'b000000); end
        checks++;
        if (obs_pulses() !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b want %b", obs_pulses(), 3'b000); end
        checks++;
        if (fkset_p !== 1'b0) begin errors++; $display("[TB] FAIL reset_fkset: got %b want 0", fkset_p); end
        reach_rxfhs();
        step(0, 1, E_TS);
        checks++;
        if (obs_flags() !== 6'b001000) begin errors++; $display("[TB] FAIL reset_pre_rxfhs: got %b want %b", obs_flags(), 6'b001000); end
        step(1, 1, E_TS); step(1, 1, E_FHS); step(1, 1, E_TS);
        checks++;
        if (obs_flags() !== 6'b000000) begin errors++; $display("[TB] FAIL reset_mid_flags: got %b want %b", obs_flags(), 6'b000000); end
        checks++;
        if (obs_pulses() !== 3'b000) begin errors++; $display("[TB] FAIL reset_mid_pulses: got %b want %b", obs_pulses(), 3'b000); end
        checks++;
        if (fkset_p !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_fkset: got %b want 0", fkset_p); end
        step(0, 0, E_CORRE);
        checks++;
        if (obs_flags() !== 6'b000000) begin errors++; $display("[TB] FAIL reset_stay_idle: got %b want %b", obs_flags(), 6'b000000); end
    endtask

    task automatic test_happy_path();
        logic [5:0] want [6] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
        int         evs  [6] = '{0, E_CORRE, E_TXD, E_FHS, E_TXD, E_POLL};
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, evs[i]);
            checks++;
            if (obs_flags() !== want[i]) begin errors++; $display("[TB] FAIL happy_step%0d: got %b want %b", i, obs_flags(), want[i]); end
            if (i == 0) begin
                step(0, 1, E_TXD | E_FHS | E_POLL | E_TS | E_DET);
                checks++;
                if (obs_flags() !== 6'b100000) begin errors++; $display("[TB] FAIL happy_ignore_in_ps: got %b want %b", obs_flags(), 6'b100000); end
            end
        end
        checks++;
        if (obs_pulses() !== 3'b001) begin errors++; $display("[TB] FAIL happy_conn_up: got %b want %b", obs_pulses(), 3'b001); end
        step(0, 0, E_TS);
        checks++;
        if (obs_pulses() !== 3'b000) begin errors++; $display("[TB] FAIL happy_conn_up_once: got %b want %b", obs_pulses(), 3'b000); end
        checks++;
        if (obs_flags() !== 6'b000001) begin errors++; $display("[TB] FAIL happy_conn_ignores_en: got %b want %b", obs_flags(), 6'b000001); end
        step(0, 0, E_DET);
        checks++;
        if (obs_flags() !== 6'b000000) begin errors++; $display("[TB] FAIL happy_detach: got %b want %b", obs_flags(), 6'b000000); end
    endtask

    task automatic test_pageresp_to();
        reach_rxfhs();
        for (int i = 1; i < PAGERESP_TO; i++) begin
            step(0, 1, E_TS);
            step(0, 1, 0);
        end
        checks++;
        if (obs_flags() !== 6'b001000 || obs_pulses() !== 3'b000) begin
            errors++; $display("[TB] FAIL presp_before_to: flags %b pulses %b want 001000 000", obs_flags(), obs_pulses());
        end
        step(0, 1, E_TS);
        checks++;
        if (obs_flags() !== 6'b100000) begin errors++; $display("[TB] FAIL presp_to_state: got %b want %b", obs_flags(), 6'b100000); end
        checks++;
        if (obs_pulses() !== 3'b100) begin errors++; $display("[TB] FAIL presp_to_pulse: got %b want %b", obs_pulses(), 3'b100); end
        step(0, 1, E_CORRE | E_TS);
        checks++;
        if (obs_pulses() !== 3'b000) begin errors++; $display("[TB] FAIL presp_to_once: got %b want %b", obs_pulses(), 3'b000); end
        checks++;
        if (obs_flags() !== 6'b010000) begin errors++; $display("[TB] FAIL presp_corre_with_tick: got %b want %b", obs_flags(), 6'b010000); end
    endtask

    task automatic test_collision();
        reach_rxfhs();
        for (int i = 1; i < PAGERESP_TO; i++) step(0, 1, E_TS);
        step(0, 1, E_TS | E_FHS);
        checks++;
        if (obs_flags() !== 6'b000100 || obs_pulses() !== 3'b000) begin
            errors++; $display("[TB] FAIL coll_fhs: flags %b pulses %b want 000100 000", obs_flags(), obs_pulses());
        end
        step(0, 1, E_TXD);
        for (int i = 1; i < NEWCONN_TO; i++) step(0, 1, E_TS);
        step(0, 1, E_TS | E_POLL);
        checks++;
        if (obs_flags() !== 6'b000001 || obs_pulses() !== 3'b001) begin
            errors++; $display("[TB] FAIL coll_poll: flags %b pulses %b want 000001 001", obs_flags(), obs_pulses());
        end
    endtask

    task automatic test_abort();
        reach_newconn();
        for (int i = 0; i < 10; i++) step(0, 1, E_TS);
        checks++;
        if (obs_flags() !== 6'b000010) begin errors++; $display("[TB] FAIL abort_in_new: got %b want %b", obs_flags(), 6'b000010); end
        step(0, 0, E_TS | E_POLL);
        checks++;
        if (obs_flags() !== 6'b000000 || obs_pulses() !== 3'b000) begin
            errors++; $display("[TB] FAIL abort_idle: flags %b pulses %b want 000000 000", obs_flags(), obs_pulses());
        end
        step(0, 1, 0); step(0, 1, E_CORRE); step(0, 1, E_TXD); step(0, 1, E_FHS); step(0, 1, E_TXD);
        for (int i = 1; i < NEWCONN_TO; i++) begin
            step(0, 1, E_TS);
            checks++;
            if (obs_flags() !== 6'b000010 || obs_pulses() !== 3'b000) begin
                errors++; $display("[TB] FAIL abort_reentry_tick%0d: flags %b pulses %b want 000010 000", i, obs_flags(), obs_pulses());
            end
        end
        step(0, 1, E_TS);
        checks++;
        if (obs_flags() !== 6'b100000 || obs_pulses() !== 3'b010) begin
            errors++; $display("[TB] FAIL abort_newconn_to: flags %b pulses %b want 100000 010", obs_flags(), obs_pulses());
        end
    endtask

    task automatic test_fkset();
`ifdef PSRESP_FKSET_GEN_EN
        bit want;
        step(1, 0, 0);
        step(0, 0, E_HTS);
        for (int k = 1; k <= 2 * HALF_SLOT + 1000; k++) begin
            step(0, 0, ((k == HALF_SLOT) ? E_HTS : 0) | (($urandom_range(1) == 1) ? E_EXT : 0));
            want = (k == FKSET_OFS - 1) || (k == HALF_SLOT + FKSET_OFS - 1);
            checks++;
            if (fkset_p !== want) begin errors++; $display("[TB] FAIL fkset_gen_k%0d: got %b want %b", k, fkset_p, want); end
        end
`else
        bit e;
        for (int k = 0; k < 64; k++) begin
            step(0, 0, 0);
            e = ($urandom_range(1) == 1);
            fkset_ext_p = e;
            m_ext = e;
            #1;
            checks++;
            if (fkset_p !== e) begin errors++; $display("[TB] FAIL fkset_pass_k%0d: got %b want %b", k, fkset_p, e); end
        end
        fkset_ext_p = 1'b0;
        m_ext = 1'b0;
`endif
    endtask

    task automatic test_random();
        bit en;
        int ev;
        en = 1;
        step(1, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            if (en && $urandom_range(299) == 0) en = 0;
            else if (!en && $urandom_range(9) == 0) en = 1;
            ev = 0;
            if ($urandom_range(5) == 0)    ev |= E_CORRE;
            if ($urandom_range(5) == 0)    ev |= E_TXD;
            if ($urandom_range(11) == 0)   ev |= E_FHS;
            if ($urandom_range(39) == 0)   ev |= E_POLL;
            if ($urandom_range(29) == 0)   ev |= E_DET;
            if ($urandom_range(3) == 0)    ev |= E_TS;
            if ($urandom_range(1499) == 0) ev |= E_HTS;
            if ($urandom_range(1) == 0)    ev |= E_EXT;
            step(0, en, ev);
            checks++;
            if (obs_flags() !== exp_flags(m_st)) begin errors++; $display("[TB] FAIL rand_flags_n%0d: got %b want %b", n, obs_flags(), exp_flags(m_st)); end
            checks++;
            if (obs_pulses() !== {m_pto, m_nto, m_up}) begin errors++; $display("[TB] FAIL rand_pulses_n%0d: got %b want %b", n, obs_pulses(), {m_pto, m_nto, m_up}); end
            checks++;
            if (fkset_p !== exp_fkset()) begin errors++; $display("[TB] FAIL rand_fkset_n%0d: got %b want %b", n, fkset_p, exp_fkset()); end
        end
    endtask

    initial begin
        $display("[TB] psresp_seq bench start");
        test_reset();
        test_happy_path();
        test_pageresp_to();
        test_collision();
        test_abort();
        test_fkset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
